add_pipe: RTL and testbench
===========================

// Module: add_pipe
// PURPOSE
//   Pipelined WIDTH-bit two's-complement adder for the Y86 execute path (addq, address calc).
//   Ripple add is split into STAGES carry-chained slices, one slice per clock, with
//   valid/ready handshakes on both sides. Companion of the combinational subtract unit.
//   Produces sum, carry-out and (optionally) Y86 condition codes ZF/SF/OF.
// PARAMETERS
//   WIDTH   64  operand/result width in bits; must be a multiple of STAGES
//   STAGES  4   pipeline depth = latency in cycles; slice width SW = WIDTH/STAGES
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operand beat offered
//   in_ready   out  1      unit accepts beat this cycle
//   a          in   WIDTH  operand A (signed)
//   b          in   WIDTH  operand B (signed)
//   cin        in   1      carry into bit 0
//   out_valid  out  1      result beat offered
//   out_ready  in   1      consumer accepts result this cycle
//   sum        out  WIDTH  a + b + cin, modulo 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
//   zf         out  1      sum == 0
//   sf         out  1      sum[WIDTH-1]
//   of         out  1      signed overflow: a[MSB]==b[MSB] && sum[MSB]!=a[MSB]
// BEHAVIOUR
//   - Global advance: adv = !out_valid || out_ready; in_ready = adv (combinational).
//   - Accept when in_valid && in_ready. Stage valid bits v[0..STAGES-1] shift on adv;
//     v[0] <= in_valid on adv. out_valid = v[STAGES-1].
//   - Stage k (0..STAGES-1) adds slice k of a/b with carry from stage k-1's register
//     (stage 0 uses cin). Unconsumed upper slices of a/b travel in skew registers;
//     finished lower sum slices travel in delay registers. Carry is registered per stage.
//   - Latency exactly STAGES cycles from acceptance to out_valid, when not stalled.
//   - Throughput 1 result/cycle while out_ready=1; results leave in acceptance order.
//   - Stall (out_valid && !out_ready): all stage registers, valid bits, and outputs hold
//     exactly; in_ready=0; no beat lost or duplicated. Bubbles are NOT collapsed.
//   - Accept and emit in the same cycle are allowed (full pipe, out_ready=1).
//   - Data registers load only on adv; a bubble (v=0) may carry don't-care data, but
//     sum/cout/flags are only meaningful while out_valid=1.
//   - Reset: all valid bits 0, sum=0, cout=0, zf=0, sf=0, of=0, in_ready=1 on the cycle
//     after rst. Reset mid-operation discards every in-flight beat; rst overrides
//     simultaneous in_valid (beat not accepted).
//   - Width rules: slice adds are SW+1 bits; cout = carry of final slice; no saturation.
//   - Zero detect is accumulated per stage (AND of per-slice zero bits), not a full
//     WIDTH-bit reduce at the output.
// CONFIGURATION
//   ADD_PIPE_FLAGS_EN defined: zf/sf/of are computed and pipelined with the beat as above;
//     a[MSB]/b[MSB] are carried to the last stage for the OF check.
//   ADD_PIPE_FLAGS_EN undefined: zf, sf, of tied to 0; no flag or sign-skew registers.
//     sum/cout/handshake behaviour is identical in both builds.
// TESTING  (WIDTH=64, STAGES=4, flags macro defined unless noted)
//   1. a=0x0000_0000_0000_FFFF, b=1, cin=0 -> 4 cycles later sum=0x10000, cout=0, zf=0,
//      sf=0, of=0 (cross-slice carry).
//   2. a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0, cout=1, zf=1, sf=0, of=0.
//   3. a=0x7FFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0x8000_0000_0000_0000, sf=1, of=1,
//      cout=0.
//   4. 6 back-to-back beats (a=i, b=10*i) with out_ready=1 -> out_valid from cycle 4,
//      sums 0,11,22,33,44,55 on consecutive cycles. Then out_ready=0 for 3 cycles with a
//      full pipe -> in_ready=0, sum held. On release, the remaining beats drain in order.
//   5. 3 beats in flight, rst pulsed 1 cycle -> out_valid=0 and all outputs 0 next cycle;
//      no stale result ever appears; a new beat then returns correctly after 4 cycles.
//   6. ADD_PIPE_FLAGS_EN undefined, repeat test 2 -> sum=0, cout=1, zf=sf=of=0.

Source files
------------

// File: rtl/add_pipe.sv
// add_pipe: pipelined WIDTH-bit two's-complement adder for the Y86 execute path.
// The ripple add is cut into STAGES carry-chained slices of SW = WIDTH/STAGES bits,
// one slice per clock. Valid/ready handshake on both sides. The whole pipe advances
// together whenever the output register is empty or being drained.
// Optional build macro: ADD_PIPE_FLAGS_EN enables the ZF/SF/OF condition codes;
// without it zf/sf/of are tied low and no flag or sign registers exist.
module add_pipe #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int unsigned SW = WIDTH / STAGES;

  logic              adv;
  logic [STAGES-1:0] v;

  assign adv       = !v[STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v[STAGES-1];

  // Stage valid bits shift together on every advance; bubbles are kept, not collapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
    end else if (adv) begin
      v[0] <= in_valid;
      for (int unsigned i = 1; i < STAGES; i++) begin
        v[i] <= v[i-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // Operand bits not yet added when the beat reaches this stage.
    localparam int unsigned AW = WIDTH - k * SW;
    // Sum bits finished once this stage has registered its slice.
    localparam int unsigned LW = (k + 1) * SW;

    logic [AW-1:0] a_av;
    logic [AW-1:0] b_av;
    logic          c_in;
    logic [SW:0]   s;
    logic [LW-1:0] lo_d;
    logic [LW-1:0] lo_q;
    logic          c_q;

    if (k == 0) begin : g_src
      assign a_av = a;
      assign b_av = b;
      assign c_in = cin;
    end else begin : g_src
      assign a_av = g_st[k-1].g_sk.a_q;
      assign b_av = g_st[k-1].g_sk.b_q;
      assign c_in = g_st[k-1].c_q;
    end

    assign s = {1'b0, a_av[SW-1:0]} + {1'b0, b_av[SW-1:0]} + {{SW{1'b0}}, c_in};

    if (k == 0) begin : g_lo
      assign lo_d = s[SW-1:0];
    end else begin : g_lo
      assign lo_d = {s[SW-1:0], g_st[k-1].lo_q};
    end

    // Slice sum joins the delayed lower slices; slice carry feeds the next stage.
    always_ff @(posedge clk) begin
      if (rst) begin
        lo_q <= '0;
        c_q  <= 1'b0;
      end else if (adv) begin
        lo_q <= lo_d;
        c_q  <= s[SW];
      end
    end

    if (k < STAGES - 1) begin : g_sk
      logic [AW-SW-1:0] a_q;
      logic [AW-SW-1:0] b_q;

      // Upper operand slices ride along until their stage consumes them.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_av[AW-1:SW];
          b_q <= b_av[AW-1:SW];
        end
      end
    end

`ifdef ADD_PIPE_FLAGS_EN
    logic z_in;
    logic sa_in;
    logic sb_in;
    logic z_q;
    logic sa_q;
    logic sb_q;

    if (k == 0) begin : g_fsrc
      assign z_in  = 1'b1;
      assign sa_in = a[WIDTH-1];
      assign sb_in = b[WIDTH-1];
    end else begin : g_fsrc
      assign z_in  = g_st[k-1].z_q;
      assign sa_in = g_st[k-1].sa_q;
      assign sb_in = g_st[k-1].sb_q;
    end

    // Zero flag accumulates one slice at a time; operand signs travel for the OF check.
    always_ff @(posedge clk) begin
      if (rst) begin
        z_q  <= 1'b0;
        sa_q <= 1'b0;
        sb_q <= 1'b0;
      end else if (adv) begin
        z_q  <= z_in && (s[SW-1:0] == '0);
        sa_q <= sa_in;
        sb_q <= sb_in;
      end
    end
`endif
  end

  assign sum  = g_st[STAGES-1].lo_q;
  assign cout = g_st[STAGES-1].c_q;

`ifdef ADD_PIPE_FLAGS_EN
  // Sign registers reset to 0, so of evaluates to 0 out of reset as well.
  assign zf = g_st[STAGES-1].z_q;
  assign sf = sum[WIDTH-1];
  assign of = (g_st[STAGES-1].sa_q == g_st[STAGES-1].sb_q) &&
              (sum[WIDTH-1] != g_st[STAGES-1].sa_q);
`else
  assign zf = 1'b0;
  assign sf = 1'b0;
  assign of = 1'b0;
`endif

endmodule

// File: tb/tb_add_pipe.sv
// Directed self-checking bench for add_pipe (WIDTH=64, STAGES=4).
// Flag expectations follow whichever build of the design is compiled.
module tb_add_pipe;

  localparam int unsigned W = 64;
  localparam int unsigned S = 4;
`ifdef ADD_PIPE_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         zf;
  logic         sf;
  logic         of;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  add_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .zf(zf), .sf(sf), .of(of)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 64'd5; b = 64'd5; cin = 1'b0;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    nvec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== '0 || cout !== 1'b0 ||
        zf !== 1'b0 || sf !== 1'b0 || of !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state: ov=%b ir=%b sum=%h cout=%b zf=%b sf=%b of=%b, required ov=0 ir=1 sum=0 cout=0 flags=000",
               out_valid, in_ready, sum, cout, zf, sf, of);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      nvec++;
      if (out_valid !== 1'b0) begin
        nerr++;
        $display("FAIL reset_beat_dropped cyc%0d: out_valid=%b, required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_vector(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                             input logic vc, input logic [W-1:0] esum, input logic ecout,
                             input logic ezf, input logic esf, input logic eof);
    in_valid = 1'b1; a = va; b = vb; cin = vc; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; a = '1; b = '1; cin = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      if (i < 4) begin
        nvec++;
        if (out_valid !== 1'b0) begin
          nerr++;
          $display("FAIL %s early_valid cyc%0d: out_valid=%b, required 0", nm, i, out_valid);
        end
      end
    end
    nvec++;
    if (out_valid !== 1'b1 || sum !== esum || cout !== ecout ||
        zf !== (FL & ezf) || sf !== (FL & esf) || of !== (FL & eof)) begin
      nerr++;
      $display("FAIL %s result: ov=%b sum=%h cout=%b zf=%b sf=%b of=%b, required ov=1 sum=%h cout=%b zf=%b sf=%b of=%b",
               nm, out_valid, sum, cout, zf, sf, of, esum, ecout, FL & ezf, FL & esf, FL & eof);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL %s drained: out_valid=%b, required 0", nm, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic         ev;
    logic         eir;
    logic [W-1:0] es;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (cyc <= 6) begin
        in_valid = 1'b1; a = 64'(cyc - 1); b = 64'(10 * (cyc - 1)); out_ready = 1'b1;
      end else if (cyc <= 9) begin
        in_valid = 1'b1; a = 64'd6; b = 64'd60; out_ready = 1'b0;
      end else if (cyc == 10) begin
        in_valid = 1'b1; a = 64'd6; b = 64'd60; out_ready = 1'b1;
      end else begin
        in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
      end
      cin = 1'b0;
      tick();
      ev  = 1'b1;
      eir = 1'b1;
      es  = '0;
      if (cyc <= 3 || cyc == 14) ev = 1'b0;
      else if (cyc <= 6) es = 64'(11 * (cyc - 4));
      else if (cyc <= 9) begin es = 64'd22; eir = 1'b0; end
      else es = 64'(11 * (cyc - 7));
      nvec++;
      if (out_valid !== ev || in_ready !== eir) begin
        nerr++;
        $display("FAIL b2b_handshake cyc%0d: ov=%b ir=%b, required ov=%b ir=%b",
                 cyc, out_valid, in_ready, ev, eir);
      end
      if (ev) begin
        nvec++;
        if (sum !== es || cout !== 1'b0 || zf !== (FL & (es == '0))) begin
          nerr++;
          $display("FAIL b2b_sum cyc%0d: sum=%0d cout=%b zf=%b, required sum=%0d cout=0 zf=%b",
                   cyc, sum, cout, zf, es, FL & (es == '0));
        end
      end
    end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b1; cin = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; a = 64'(i); b = 64'd100;
      tick();
    end
    in_valid = 1'b0;
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL flush_pre: out_valid=%b, required 0", out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nvec++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || zf !== 1'b0 ||
        sf !== 1'b0 || of !== 1'b0 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL flush_reset: ov=%b ir=%b sum=%h cout=%b zf=%b sf=%b of=%b, required ov=0 ir=1 all zero",
               out_valid, in_ready, sum, cout, zf, sf, of);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      nvec++;
      if (out_valid !== 1'b0) begin
        nerr++;
        $display("FAIL flush_stale cyc%0d: out_valid=%b sum=%h, required ov=0", i, out_valid, sum);
      end
    end
    test_vector("flush_new", 64'h1234, 64'h1111, 1'b0, 64'h2345, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_vector("cross_slice", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0,
                64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    test_vector("wrap_zero", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                64'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    test_vector("pos_overflow", 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1,
                64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
    test_vector("neg_overflow", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                64'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    test_vector("cin_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1,
                64'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    test_vector("neg_result", 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    test_back_to_back();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
